// File: rtl/pss_tracker_pkg.sv
// pss_tracker_pkg: detector mode encodings and default timing constants.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// The mode encoding is shared with the PSS detector's mode_i input, so the
// values must not be renumbered.
package pss_tracker_pkg;

   typedef enum logic [1:0] {
      MODE_SEARCH = 2'd0,
      MODE_FIND   = 2'd1,
      MODE_PAUSE  = 2'd2
   } mode_e;

   // 20 ms SSB period at 1.92 MSPS, +/-100 sample find window.
   localparam int DEF_SSB_INTERVAL    = 38400;
   localparam int DEF_TRACK_TOLERANCE = 100;
   localparam int DEF_MAX_MISSES      = 3;

endpackage

// File: rtl/pss_tracker_if.sv
// pss_tracker_if: detector <-> tracker signal bundle.
// Latency: n/a (wiring only).
// Backpressure: none; strobes and detection pulses are single-cycle events.
//
// Ports (signal names follow the tracker's point of view):
//   s_axis_in_tvalid, N_id_2_i, N_id_2_valid_i   detector side -> tracker
//   mode_o, requested_N_id_2_o                   tracker -> detector control
//   locked_o, ssb_start_o, lost_o,
//   sample_cnt_o, miss_cnt_o                     tracker status
// master: the side producing samples/detections (detector or bench).
// slave : the tracker.
interface pss_tracker_if #(
   parameter int CNT_DW = 16,
   parameter int MISS_W = 2
);
   logic              s_axis_in_tvalid;
   logic [1:0]        N_id_2_i;
   logic              N_id_2_valid_i;
   logic [1:0]        mode_o;
   logic [1:0]        requested_N_id_2_o;
   logic              locked_o;
   logic              ssb_start_o;
   logic              lost_o;
   logic [CNT_DW-1:0] sample_cnt_o;
   logic [MISS_W-1:0] miss_cnt_o;

   modport master (
      output s_axis_in_tvalid, N_id_2_i, N_id_2_valid_i,
      input  mode_o, requested_N_id_2_o, locked_o, ssb_start_o, lost_o,
             sample_cnt_o, miss_cnt_o
   );

   modport slave (
      input  s_axis_in_tvalid, N_id_2_i, N_id_2_valid_i,
      output mode_o, requested_N_id_2_o, locked_o, ssb_start_o, lost_o,
             sample_cnt_o, miss_cnt_o
   );
endinterface

// File: rtl/pss_tracker.sv
// pss_tracker: SSB timing tracker closing the loop around the PSS detector.
// Latency: 1 cycle from strobe/detection input to every registered output.
// Backpressure: none; every strobe and detection pulse is consumed, never stalls.
//
// Ports:
//   clk_i     detector clock
//   reset_ni  asynchronous active-low reset
//   bus       pss_tracker_if.slave: sample strobe and detections in; detector
//             mode, requested N_id_2, lock state, ssb_start/lost pulses and
//             the sample/miss counters out.
// The bus instance must be built with CNT_DW and MISS_W matching this module.
// MAX_MISSES must be at least 1.
module pss_tracker
   import pss_tracker_pkg::*;
#(
   parameter int SSB_INTERVAL    = DEF_SSB_INTERVAL,
   parameter int TRACK_TOLERANCE = DEF_TRACK_TOLERANCE,
   parameter int MAX_MISSES      = DEF_MAX_MISSES,
   parameter int CNT_DW          = $clog2(SSB_INTERVAL + TRACK_TOLERANCE + 1)
) (
   input  logic        clk_i,
   input  logic        reset_ni,
   pss_tracker_if.slave bus
);

   localparam int MISS_W = $clog2(MAX_MISSES + 1);

   // Last count of the pause phase: the strobe seen at this count opens FIND.
   localparam logic [CNT_DW-1:0] PAUSE_END = CNT_DW'(SSB_INTERVAL - TRACK_TOLERANCE - 1);
   // Last count of the find window: a strobe here without a hit is a miss.
   localparam logic [CNT_DW-1:0] WIN_END   = CNT_DW'(SSB_INTERVAL + TRACK_TOLERANCE - 1);
   // Coasting re-anchors onto the nominal grid: the window opened TOLERANCE
   // samples before the expected SSB, so "now" is TOLERANCE past it.
   localparam logic [CNT_DW-1:0] COAST_CNT = CNT_DW'(TRACK_TOLERANCE);
   // miss_cnt value at which one more miss abandons tracking.
   localparam logic [MISS_W-1:0] MISS_LAST = MISS_W'(MAX_MISSES - 1);

   mode_e             state_q;
   logic [1:0]        req_q;
   logic              locked_q;
   logic              ssb_start_q;
   logic              lost_q;
   logic [CNT_DW-1:0] cnt_q;
   logic [MISS_W-1:0] miss_q;

   logic hit;
   logic expiry;

   assign hit    = bus.N_id_2_valid_i && (bus.N_id_2_i == req_q);
   assign expiry = bus.s_axis_in_tvalid && (cnt_q == WIN_END);

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q     <= MODE_SEARCH;
         req_q       <= 2'd0;
         locked_q    <= 1'b0;
         ssb_start_q <= 1'b0;
         lost_q      <= 1'b0;
         cnt_q       <= '0;
         miss_q      <= '0;
      end else begin
         ssb_start_q <= 1'b0;
         lost_q      <= 1'b0;
         case (state_q)
            MODE_SEARCH: begin
               // Any detection is accepted, with or without a strobe; the
               // detection sample itself is count 0.
               if (bus.N_id_2_valid_i) begin
                  req_q       <= bus.N_id_2_i;
                  cnt_q       <= '0;
                  miss_q      <= '0;
                  ssb_start_q <= 1'b1;
                  state_q     <= MODE_PAUSE;
               end
            end

            MODE_PAUSE: begin
               // Detections are deliberately ignored while the correlators idle.
               if (bus.s_axis_in_tvalid) begin
                  cnt_q <= cnt_q + CNT_DW'(1);
                  if (cnt_q == PAUSE_END) begin
                     state_q <= MODE_FIND;
                  end
               end
            end

            MODE_FIND: begin
               // The hit check comes first so a hit on the expiry strobe wins
               // and is not counted as a miss.
               if (hit) begin
                  cnt_q       <= '0;
                  miss_q      <= '0;
                  locked_q    <= 1'b1;
                  ssb_start_q <= 1'b1;
                  state_q     <= MODE_PAUSE;
               end else if (expiry) begin
                  if (miss_q == MISS_LAST) begin
                     cnt_q    <= '0;
                     miss_q   <= '0;
                     locked_q <= 1'b0;
                     lost_q   <= 1'b1;
                     state_q  <= MODE_SEARCH;
                  end else begin
                     cnt_q   <= COAST_CNT;
                     miss_q  <= miss_q + MISS_W'(1);
                     state_q <= MODE_PAUSE;
                  end
               end else if (bus.s_axis_in_tvalid) begin
                  cnt_q <= cnt_q + CNT_DW'(1);
               end
            end

            default: begin
               state_q <= MODE_SEARCH;
            end
         endcase
      end
   end

   assign bus.mode_o             = state_q;
   assign bus.requested_N_id_2_o = req_q;
   assign bus.locked_o           = locked_q;
   assign bus.ssb_start_o        = ssb_start_q;
   assign bus.lost_o             = lost_q;
   assign bus.sample_cnt_o       = cnt_q;
   assign bus.miss_cnt_o         = miss_q;

endmodule

// File: tb/tb_pss_tracker.sv
// tb_pss_tracker: directed table plus randomized run against a count-based model.
// Latency: checks outputs 1 ns after each rising edge.
// Backpressure: n/a.
module tb_pss_tracker;

   localparam int SSB    = 1000;
   localparam int TOL    = 10;
   localparam int MAXM   = 2;
   localparam int CNT_DW = $clog2(SSB + TOL + 1);
   localparam int MISS_W = $clog2(MAXM + 1);

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_err;

   pss_tracker_if #(.CNT_DW(CNT_DW), .MISS_W(MISS_W)) bus ();

   pss_tracker #(
      .SSB_INTERVAL   (SSB),
      .TRACK_TOLERANCE(TOL),
      .MAX_MISSES     (MAXM)
   ) dut (
      .clk_i   (clk),
      .reset_ni(rst_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int         gap;      // strobe-only cycles before the vector cycle
      logic       tv;
      logic       vld;
      logic [1:0] id;
      logic [1:0] e_mode;
      logic [1:0] e_req;
      logic       e_locked;
      logic       e_ssb;
      logic       e_lost;
      int         e_cnt;
      bit         cnt_chk;
      int         e_miss;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(int gap, logic tv, logic vld, logic [1:0] id,
                               logic [1:0] m, logic [1:0] rq, logic lk, logic ss,
                               logic ls, int cnt, bit cc, int miss);
      vec_t v;
      v.gap = gap; v.tv = tv; v.vld = vld; v.id = id;
      v.e_mode = m; v.e_req = rq; v.e_locked = lk; v.e_ssb = ss; v.e_lost = ls;
      v.e_cnt = cnt; v.cnt_chk = cc; v.e_miss = miss;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic step(input logic tv, input logic v, input logic [1:0] id);
      @(negedge clk);
      bus.s_axis_in_tvalid = tv;
      bus.N_id_2_valid_i   = v;
      bus.N_id_2_i         = id;
      @(posedge clk);
      #1;
   endtask

   // Reference model: tracks samples since the anchor as a plain integer and
   // derives the phase (pause / window) from that distance.
   bit         m_acq;
   int         m_n;
   int         m_miss;
   bit         m_locked;
   logic [1:0] m_req;
   bit         m_ssb;
   bit         m_lost;

   function automatic logic [1:0] m_mode();
      if (!m_acq)          return 2'd0;
      else if (m_n < SSB - TOL) return 2'd2;
      else                 return 2'd1;
   endfunction

   task automatic model_reset();
      m_acq = 0; m_n = 0; m_miss = 0; m_locked = 0; m_req = 2'd0; m_ssb = 0; m_lost = 0;
   endtask

   task automatic model_step(input logic tv, input logic v, input logic [1:0] id);
      m_ssb  = 0;
      m_lost = 0;
      if (!m_acq) begin
         if (v) begin
            m_acq = 1; m_req = id; m_n = 0; m_miss = 0; m_ssb = 1;
         end
      end else if (m_n < SSB - TOL) begin
         if (tv) m_n++;
      end else begin
         if (v && id == m_req) begin
            m_n = 0; m_miss = 0; m_locked = 1; m_ssb = 1;
         end else if (tv) begin
            if (m_n == SSB + TOL - 1) begin
               if (m_miss + 1 == MAXM) begin
                  m_acq = 0; m_locked = 0; m_miss = 0; m_lost = 1; m_n = 0;
               end else begin
                  m_miss++; m_n = TOL;
               end
            end else begin
               m_n++;
            end
         end
      end
   endtask

   initial begin
      int quiet;
      logic [CNT_DW+8:0] act_v;
      logic [CNT_DW+8:0] exp_v;
      logic tv, v;
      logic [1:0] id;

      n_checks = 0;
      n_err    = 0;
      rst_n    = 1'b0;
      bus.s_axis_in_tvalid = 1'b0;
      bus.N_id_2_valid_i   = 1'b0;
      bus.N_id_2_i         = 2'd0;

      //          gap  tv vld id  mode req lk ss ls  cnt cc miss
      vecs.push_back(mk(4,    1, 1, 1,  2, 1, 0, 1, 0, 0,   1, 0)); // acquisition
      vecs.push_back(mk(988,  1, 0, 0,  2, 1, 0, 0, 0, 989, 1, 0)); // last pause count
      vecs.push_back(mk(0,    1, 0, 0,  1, 1, 0, 0, 0, 990, 1, 0)); // FIND after 990 strobes
      vecs.push_back(mk(2,    1, 1, 2,  1, 1, 0, 0, 0, 993, 1, 0)); // wrong ID ignored
      vecs.push_back(mk(10,   1, 1, 1,  2, 1, 1, 1, 0, 0,   1, 0)); // hit at 1003 -> lock
      vecs.push_back(mk(1009, 1, 0, 0,  2, 1, 1, 0, 0, 10,  1, 1)); // miss, coast
      vecs.push_back(mk(990,  1, 1, 1,  2, 1, 1, 1, 0, 0,   1, 0)); // recover
      vecs.push_back(mk(1009, 1, 1, 1,  2, 1, 1, 1, 0, 0,   1, 0)); // hit on expiry strobe
      vecs.push_back(mk(995,  0, 1, 1,  2, 1, 1, 1, 0, 0,   1, 0)); // hit with no strobe
      vecs.push_back(mk(1009, 1, 0, 0,  2, 1, 1, 0, 0, 10,  1, 1)); // miss 1
      vecs.push_back(mk(999,  1, 0, 0,  0, 1, 0, 0, 1, 0,   0, 0)); // miss 2 -> lost
      vecs.push_back(mk(5,    0, 1, 2,  2, 2, 0, 1, 0, 0,   1, 0)); // reacquire, no strobe
      vecs.push_back(mk(3,    1, 1, 0,  2, 2, 0, 0, 0, 4,   1, 0)); // detection in PAUSE ignored
      vecs.push_back(mk(990,  1, 1, 2,  2, 2, 1, 1, 0, 0,   1, 0)); // lock on ID 2
      vecs.push_back(mk(1009, 1, 0, 0,  2, 2, 1, 0, 0, 10,  1, 1)); // miss 1
      vecs.push_back(mk(5,    1, 0, 0,  2, 2, 1, 0, 0, 16,  1, 1)); // mid-PAUSE

      // Reset state.
      repeat (3) @(posedge clk);
      #1;
      chk("reset_mode",   bus.mode_o, 0);
      chk("reset_req",    bus.requested_N_id_2_o, 0);
      chk("reset_locked", bus.locked_o, 0);
      chk("reset_ssb",    bus.ssb_start_o, 0);
      chk("reset_lost",   bus.lost_o, 0);
      chk("reset_cnt",    bus.sample_cnt_o, 0);
      chk("reset_miss",   bus.miss_cnt_o, 0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         quiet = 0;
         for (int g = 0; g < vecs[i].gap; g++) begin
            step(1'b1, 1'b0, 2'd0);
            if (bus.ssb_start_o || bus.lost_o) quiet++;
         end
         if (vecs[i].gap > 0) chk($sformatf("v%0d_gap_pulses", i), quiet, 0);
         step(vecs[i].tv, vecs[i].vld, vecs[i].id);
         chk($sformatf("v%0d_mode", i),   bus.mode_o, vecs[i].e_mode);
         chk($sformatf("v%0d_req", i),    bus.requested_N_id_2_o, vecs[i].e_req);
         chk($sformatf("v%0d_locked", i), bus.locked_o, vecs[i].e_locked);
         chk($sformatf("v%0d_ssb", i),    bus.ssb_start_o, vecs[i].e_ssb);
         chk($sformatf("v%0d_lost", i),   bus.lost_o, vecs[i].e_lost);
         if (vecs[i].cnt_chk) chk($sformatf("v%0d_cnt", i), bus.sample_cnt_o, vecs[i].e_cnt);
         chk($sformatf("v%0d_miss", i),   bus.miss_cnt_o, vecs[i].e_miss);
      end

      // Asynchronous reset mid-PAUSE while locked with one miss outstanding.
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_mode",   bus.mode_o, 0);
      chk("async_rst_req",    bus.requested_N_id_2_o, 0);
      chk("async_rst_locked", bus.locked_o, 0);
      chk("async_rst_cnt",    bus.sample_cnt_o, 0);
      chk("async_rst_miss",   bus.miss_cnt_o, 0);
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         step(1'b1, 1'b0, 2'd0);
         chk($sformatf("post_rst%0d_ssb", k),  bus.ssb_start_o, 0);
         chk($sformatf("post_rst%0d_lost", k), bus.lost_o, 0);
         chk($sformatf("post_rst%0d_mode", k), bus.mode_o, 0);
      end
      step(1'b1, 1'b1, 2'd3);
      chk("post_rst_acq_mode", bus.mode_o, 2);
      chk("post_rst_acq_req",  bus.requested_N_id_2_o, 3);
      chk("post_rst_acq_ssb",  bus.ssb_start_o, 1);

      // Randomized run against the model.
      @(negedge clk);
      rst_n = 1'b0;
      bus.s_axis_in_tvalid = 1'b0;
      bus.N_id_2_valid_i   = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      for (int c = 0; c < 30000; c++) begin
         tv = ($urandom_range(3) != 0);
         v  = ($urandom_range(29) == 0);
         id = 2'($urandom_range(3));
         step(tv, v, id);
         model_step(tv, v, id);
         act_v = {bus.mode_o, bus.requested_N_id_2_o, bus.locked_o, bus.ssb_start_o,
                  bus.lost_o, bus.sample_cnt_o, bus.miss_cnt_o};
         exp_v = {m_mode(), m_req, m_locked, m_ssb, m_lost, CNT_DW'(m_n), MISS_W'(m_miss)};
         // The counter value while searching carries no meaning.
         if (!m_acq) begin
            act_v[CNT_DW+MISS_W-1:MISS_W] = '0;
            exp_v[CNT_DW+MISS_W-1:MISS_W] = '0;
         end
         n_checks++;
         if (act_v !== exp_v) begin
            n_err++;
            $display("FAIL rand_c%0d: got mode=%0d req=%0d lk=%0d ssb=%0d lost=%0d cnt=%0d miss=%0d expected mode=%0d req=%0d lk=%0d ssb=%0d lost=%0d cnt=%0d miss=%0d",
                     c, bus.mode_o, bus.requested_N_id_2_o, bus.locked_o, bus.ssb_start_o,
                     bus.lost_o, bus.sample_cnt_o, bus.miss_cnt_o,
                     m_mode(), m_req, m_locked, m_ssb, m_lost, m_n, m_miss);
         end
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/pss_tracker.md
# pss_tracker

Timing tracker directly downstream of the PSS detector. It consumes the detector's N_id_2 detections and drives the detector's `mode_i` / `requested_N_id_2_i` inputs, closing the loop. After a first detection it pauses the correlators until the next expected SSB. It then opens a FIND window of ±TRACK_TOLERANCE samples around the expected position, declares lock on a confirmed hit, and falls back to SEARCH after MAX_MISSES consecutive missed windows.

## Interface
Parameters:
- SSB_INTERVAL, 38400: nominal SSB period in samples (20 ms at 1.92 MSPS).
- TRACK_TOLERANCE, 100: half-width of the FIND window in samples.
- MAX_MISSES, 3: consecutive missed windows before lock is dropped; must be ≥ 1.
- CNT_DW, $clog2(SSB_INTERVAL + TRACK_TOLERANCE + 1): width of the sample counter (derived).

Ports:
- clk_i  in  1  clock; one clock, the same as the detector.
- reset_ni  in  1  reset, asynchronous and active-low.
- s_axis_in_tvalid  in  1  sample strobe; the counter advances only on this strobe.
- N_id_2_i  in  2  detected N_id_2.
- N_id_2_valid_i  in  1  single-cycle detection pulse from the detector.
- mode_o  out  2  detector mode: 0 SEARCH, 1 FIND, 2 PAUSE.
- requested_N_id_2_o  out  2  N_id_2 the detector restricts itself to in FIND.
- locked_o  out  1  tracking is confirmed.
- ssb_start_o  out  1  single-cycle pulse per accepted detection, including the first.
- lost_o  out  1  single-cycle pulse when lock or acquisition is abandoned.
- sample_cnt_o  out  CNT_DW  samples since the last accepted detection or coast point.
- miss_cnt_o  out  $clog2(MAX_MISSES+1)  current count of consecutive misses.

## Operation
States are SEARCH, PAUSE and FIND; mode_o equals the state encoding.

SEARCH:
- On N_id_2_valid_i: latch N_id_2_i into requested_N_id_2_o, set sample_cnt to 0, clear miss_cnt, pulse ssb_start_o, go to PAUSE. locked_o stays 0.

PAUSE:
- sample_cnt increments on each s_axis_in_tvalid.
- N_id_2_valid_i is ignored.
- When a strobe arrives with sample_cnt == SSB_INTERVAL − TRACK_TOLERANCE − 1, go to FIND.

FIND:
- sample_cnt keeps incrementing.
- Hit: N_id_2_valid_i with N_id_2_i == requested_N_id_2_o.
  - sample_cnt set to 0, miss_cnt cleared, locked_o set to 1, ssb_start_o pulsed, go to PAUSE.
- A detection with any other N_id_2 is ignored.
- Window expiry: a strobe with sample_cnt == SSB_INTERVAL + TRACK_TOLERANCE − 1 and no hit in that cycle.
  - If miss_cnt + 1 == MAX_MISSES: go to SEARCH, clear locked_o, clear miss_cnt, pulse lost_o.
  - Otherwise: increment miss_cnt, coast by setting sample_cnt to TRACK_TOLERANCE (the nominal grid), go to PAUSE.

Arithmetic and width rules:
- The counter is unsigned CNT_DW bits.
- Compare constants are computed at elaboration.
- The counter never wraps: it is bounded by the window-expiry value.

## Timing
- All outputs are registered.
- Reset values: mode_o = 0 (SEARCH), requested_N_id_2_o = 0, locked_o = 0, ssb_start_o = 0, lost_o = 0, sample_cnt_o = 0, miss_cnt_o = 0.
- A state change and its mode_o value appear on the clock edge that samples the triggering event, so latency is 1 cycle from input to output.
- A detection pulse and a sample strobe in the same cycle: the detection wins and the counter loads 0. The detection sample is count 0.
- Hit and window expiry in the same cycle: the hit wins, and the cycle is not counted as a miss.
- N_id_2_valid_i with no strobe is still accepted.
- Reset asserted mid-operation: immediate return to SEARCH with all reset values. No pulse is emitted on reset release.
- ssb_start_o and lost_o are never high in the same cycle.

## Structure
- A shared package `pss_tracker_pkg` holds:
  - the mode encodings (SEARCH = 2'd0, FIND = 2'd1, PAUSE = 2'd2), used identically by the PSS detector;
  - the default SSB_INTERVAL and TRACK_TOLERANCE constants.
- Single module with no sub-modules. The counter and FSM live in one sequential process with async reset.

## Test plan
All scenarios use SSB_INTERVAL = 1000, TRACK_TOLERANCE = 10, MAX_MISSES = 2, and a strobe every cycle unless stated.

- Acquisition:
  - Stimulus: detection N_id_2 = 1 at cycle 5.
  - Response: cycle 6 shows mode_o = 2, requested_N_id_2_o = 1, ssb_start_o = 1, locked_o = 0.
  - Response: mode_o = 1 (FIND) starting 990 strobes after the detection.
- Tracking hit:
  - Stimulus: a second detection N_id_2 = 1 at 1003 samples after the first.
  - Response: locked_o = 1, sample_cnt_o = 0, mode_o = 2, ssb_start_o pulse.
- Wrong ID in window:
  - Stimulus: detection N_id_2 = 2 during FIND.
  - Response: ignored, state stays FIND, no pulse.
- Miss then recover:
  - Stimulus: no detection through the window.
  - Response: miss_cnt_o = 1, sample_cnt_o = 10, mode_o = 2, locked_o stays 1.
  - Stimulus: next window hits.
  - Response: miss_cnt_o = 0.
- Loss:
  - Stimulus: two consecutive missed windows.
  - Response: lost_o pulse, locked_o = 0, mode_o = 0.
- Boundary and reset:
  - Stimulus: hit coincident with the expiry strobe (sample_cnt = 1009).
  - Response: accepted as a hit, miss_cnt_o unchanged at 0.
  - Stimulus: reset_ni pulsed low mid-PAUSE.
  - Response: all outputs return to reset values asynchronously.
